// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared fetch/decode constants and queue entry type
package fetch_queue_pkg;

   localparam int INSTR_W = 64;
   localparam int PC_W    = 64;

   // Presented to decode whenever no real instruction is available.
   localparam logic [0:INSTR_W-1] STALL_INSTRUCTION = 64'h0000_0000_0000_0013;

   typedef struct packed {
      logic [0:INSTR_W-1] instr;
      logic [0:PC_W-1]    pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular instruction queue between fetch and decode
// Halt masks the head without losing entries; flush discards everything.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int INSTR_W = fetch_queue_pkg::INSTR_W,
   parameter int PC_W    = fetch_queue_pkg::PC_W,
   parameter int DEPTH   = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     halt,
   input  logic                     flush,
   input  logic                     in_valid,
   input  logic [0:INSTR_W-1]       in_instr,
   input  logic [0:PC_W-1]          in_pc,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [0:INSTR_W-1]       out_instr,
   output logic [0:PC_W-1]          out_pc,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   fetch_entry_t mem_q [DEPTH];

   logic [PTR_W-1:0] wp_q, wp_d;
   logic [PTR_W-1:0] rp_q, rp_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic full, empty, push, pop;
   fetch_entry_t head;

   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);

   // No pass-through: a same-cycle pop never frees a slot for a push.
   assign in_ready  = !full && !flush;
   assign out_valid = !empty && !halt;

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;

   assign head      = mem_q[rp_q];
   assign out_instr = out_valid ? head.instr : STALL_INSTRUCTION;
   assign out_pc    = out_valid ? head.pc : '0;
   assign count     = count_q;

   always_comb begin
      wp_d    = wp_q;
      rp_d    = rp_q;
      count_d = count_q;
      if (flush) begin
         wp_d    = '0;
         rp_d    = '0;
         count_d = '0;
      end else begin
         if (push) wp_d = wp_q + 1'b1;
         if (pop)  rp_d = rp_q + 1'b1;
         if (push && !pop)      count_d = count_q + 1'b1;
         else if (pop && !push) count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp_q    <= '0;
         rp_q    <= '0;
         count_q <= '0;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         count_q <= count_d;
      end
   end

   // Storage is left unreset; empty masks whatever it holds.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wp_q].instr <= in_instr;
         mem_q[wp_q].pc    <= in_pc;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;
   import fetch_queue_pkg::*;

   logic          clk = 1'b0;
   logic          rst;
   logic          halt;
   logic          flush;
   logic          in_valid;
   logic [0:63]   in_instr;
   logic [0:63]   in_pc;
   logic          in_ready;
   logic          out_valid;
   logic [0:63]   out_instr;
   logic [0:63]   out_pc;
   logic          out_ready;
   logic [2:0]    count;

   int total = 0;
   int bad   = 0;

   fetch_queue #(.INSTR_W(64), .PC_W(64), .DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .halt      (halt),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_instr  (in_instr),
      .in_pc     (in_pc),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_instr (out_instr),
      .out_pc    (out_pc),
      .out_ready (out_ready),
      .count     (count)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] mk_instr(input logic [63:0] pc);
      return 64'hC0DE_0000_0000_0000 ^ (pc << 4) ^ pc;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks land mid-cycle.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [63:0] pc, input logic rdy);
      in_valid  = v;
      in_pc     = pc;
      in_instr  = mk_instr(pc);
      out_ready = rdy;
   endtask

   task automatic settle();
      #3;
   endtask

   initial begin
      rst = 1'b0; halt = 1'b0; flush = 1'b0;
      drive(1'b0, 64'h0, 1'b0);

      // Reset then idle
      step(); step();
      rst = 1'b1;
      step(); settle();
      check("reset_count", 64'(count), 64'd0);
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_out_instr", out_instr, STALL_INSTRUCTION);
      check("reset_out_pc", out_pc, 64'd0);
      check("reset_in_ready", 64'(in_ready), 64'd1);

      // Fill to DEPTH with decode stalled
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 64'h100 + 64'(4 * i), 1'b0);
         settle();
         check("fill_in_ready", 64'(in_ready), 64'd1);
         step();
      end
      settle();
      check("full_count", 64'(count), 64'd4);
      check("full_in_ready", 64'(in_ready), 64'd0);
      check("full_head_pc", out_pc, 64'h100);
      drive(1'b1, 64'h110, 1'b0);
      step(); settle();
      check("full_push_refused", 64'(count), 64'd4);

      // Drain in order
      drive(1'b0, 64'h0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         settle();
         check("drain_valid", 64'(out_valid), 64'd1);
         check("drain_pc", out_pc, 64'h100 + 64'(4 * i));
         check("drain_instr", out_instr, mk_instr(64'h100 + 64'(4 * i)));
         step();
         if (i == 0) begin
            settle();
            check("full_pop_count", 64'(count), 64'd3);
            check("full_pop_in_ready", 64'(in_ready), 64'd1);
         end
      end
      settle();
      check("drained_count", 64'(count), 64'd0);
      check("drained_out_valid", 64'(out_valid), 64'd0);
      step(); settle();
      check("empty_pop_count", 64'(count), 64'd0);
      check("empty_pop_pc", out_pc, 64'd0);

      // Streaming across pointer wrap at count=1
      drive(1'b1, 64'h300, 1'b0);
      step(); settle();
      check("empty_push_count", 64'(count), 64'd1);
      check("empty_push_valid", 64'(out_valid), 64'd1);
      for (int k = 0; k < 20; k++) begin
         drive(1'b1, 64'h304 + 64'(4 * k), 1'b1);
         settle();
         check("stream_pc", out_pc, 64'h300 + 64'(4 * k));
         check("stream_in_ready", 64'(in_ready), 64'd1);
         step(); settle();
         check("stream_count", 64'(count), 64'd1);
      end
      drive(1'b0, 64'h0, 1'b1);
      settle();
      check("stream_last_pc", out_pc, 64'h350);
      step(); settle();
      check("stream_drained", 64'(count), 64'd0);

      // Halt with two entries queued, pushing during halt
      drive(1'b1, 64'h200, 1'b0);
      step();
      drive(1'b1, 64'h204, 1'b0);
      step(); settle();
      check("halt_pre_count", 64'(count), 64'd2);
      halt = 1'b1;
      drive(1'b1, 64'h208, 1'b1);
      for (int h = 0; h < 3; h++) begin
         settle();
         check("halt_out_valid", 64'(out_valid), 64'd0);
         check("halt_out_instr", out_instr, STALL_INSTRUCTION);
         check("halt_out_pc", out_pc, 64'd0);
         step();
         drive(1'b0, 64'h0, 1'b1);
         settle();
         check("halt_count", 64'(count), 64'd3);
      end
      halt = 1'b0;
      drive(1'b0, 64'h0, 1'b0);
      settle();
      check("halt_release_valid", 64'(out_valid), 64'd1);
      check("halt_release_pc", out_pc, 64'h200);
      check("halt_release_instr", out_instr, mk_instr(64'h200));

      // Flush beats a same-cycle push and pop
      flush = 1'b1;
      drive(1'b1, 64'h20C, 1'b1);
      settle();
      check("flush_in_ready", 64'(in_ready), 64'd0);
      step();
      flush = 1'b0;
      drive(1'b0, 64'h0, 1'b0);
      settle();
      check("flush_count", 64'(count), 64'd0);
      check("flush_out_valid", 64'(out_valid), 64'd0);
      drive(1'b1, 64'h400, 1'b0);
      step();
      drive(1'b0, 64'h0, 1'b0);
      settle();
      check("post_flush_count", 64'(count), 64'd1);
      check("post_flush_head", out_pc, 64'h400);

      // Halt together with flush: flush wins
      halt = 1'b1; flush = 1'b1;
      step();
      halt = 1'b0; flush = 1'b0;
      settle();
      check("halt_flush_count", 64'(count), 64'd0);
      check("halt_flush_valid", 64'(out_valid), 64'd0);

      // Asynchronous reset between edges
      drive(1'b1, 64'h500, 1'b0);
      step();
      drive(1'b1, 64'h504, 1'b0);
      step();
      drive(1'b0, 64'h0, 1'b0);
      settle();
      check("areset_pre_count", 64'(count), 64'd2);
      rst = 1'b0;
      #1;
      check("areset_out_valid", 64'(out_valid), 64'd0);
      check("areset_count", 64'(count), 64'd0);
      check("areset_in_ready", 64'(in_ready), 64'd1);
      step();
      rst = 1'b1;
      drive(1'b1, 64'h600, 1'b0);
      step();
      drive(1'b0, 64'h0, 1'b0);
      settle();
      check("areset_first_push_count", 64'(count), 64'd1);
      check("areset_first_push_pc", out_pc, 64'h600);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction queue between the fetch stage and decode, replacing the single-entry fetch buffer. It holds up to DEPTH fetched instructions with their PCs and uses valid/ready handshakes on both sides. It supports a pipeline halt that injects STALL_INSTRUCTION without losing queued entries, and a redirect flush that discards all queued entries.

## Interface
- INSTR_W, 64, instruction width in bits
- PC_W, 64, program-counter width in bits
- DEPTH, 4, number of entries; power of two, at least 2

- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- halt  in  1  decode-side stall; masks the output and blocks pops
- flush  in  1  redirect; discards all entries at the next edge
- in_valid  in  1  fetch presents an instruction
- in_instr  in  [0:INSTR_W-1]  fetched instruction
- in_pc  in  [0:PC_W-1]  PC of in_instr
- in_ready  out  1  queue can accept an instruction this cycle
- out_valid  out  1  head entry is presented to decode
- out_instr  out  [0:INSTR_W-1]  head instruction, or STALL_INSTRUCTION when out_valid=0
- out_pc  out  [0:PC_W-1]  head PC, or 0 when out_valid=0
- out_ready  in  1  decode takes the head entry this cycle
- count  out  [$clog2(DEPTH):0]  current occupancy, 0..DEPTH

## Operation
- Storage is a circular buffer with a write pointer (wp) and a read pointer (rp), each $clog2(DEPTH) bits wide.
  - Pointers wrap modulo DEPTH by natural overflow.
  - count is tracked explicitly; full means count==DEPTH, empty means count==0.
- Push occurs when in_valid && in_ready:
  - the entry is written at wp and wp increments.
- in_ready = !full && !flush.
  - No pass-through from a same-cycle pop; in_ready is 0 when full even if a pop occurs.
- out_valid = !empty && !halt.
- Pop occurs when out_valid && out_ready:
  - rp increments.
- out_instr and out_pc show the head entry when out_valid=1. Otherwise they show STALL_INSTRUCTION and 0.
- count next value:
  - push and pop together: unchanged
  - push only: +1
  - pop only: -1
- Flush has priority over everything:
  - wp, rp and count become 0 at the next edge.
  - Any same-cycle push or pop has no effect.
- Halt:
  - freezes rp and blocks pops;
  - pushes continue while !full;
  - on deassertion, the original head reappears unchanged.
- Reset (rst=0, asynchronous):
  - wp=0, rp=0, count=0, so out_valid=0, out_instr=STALL_INSTRUCTION, out_pc=0, in_ready=1.
  - Storage array is not reset; outputs are masked by empty.

## Timing
- Latency: an entry pushed at edge N is visible on out_* in the cycle after edge N (1 cycle). No combinational in→out bypass when empty.
- out_valid, out_instr and out_pc depend combinationally on registered state and halt only.
- in_ready depends combinationally on registered state and flush only. There is no path from out_ready to in_ready.
- Back-to-back: with count between 1 and DEPTH-1, the queue sustains one push and one pop per cycle indefinitely.
- Boundary conditions:
  - Full with push attempted: refused, in_ready=0.
  - Full with pop: count becomes DEPTH-1, so in_ready=1 in the next cycle.
  - Empty with pop attempted: out_valid=0, so no pop and no underflow.
  - Empty with push: count becomes 1, out_valid=1 in the next cycle if !halt.
  - Halt together with flush: flush applies; queue empty after the edge.
  - Reset asserted mid-burst: state clears immediately. First push is accepted on the first edge with rst=1.

## Structure
- Shared header package:
  - STALL_INSTRUCTION (existing);
  - a fetch_entry_t packed struct {instr, pc}, sized by the package INSTR_W and PC_W constants.
- Single module. Storage is a flat array of fetch_entry_t. No sub-module is warranted; the pointer and count logic is a few lines.

## Test plan
- Reset then idle:
  - Stimulus: rst=0 for 2 cycles, release, hold in_valid=0.
  - Required: count=0, out_valid=0, out_instr=STALL_INSTRUCTION, in_ready=1.
- Fill and drain with DEPTH=4:
  - Stimulus: push PCs 0x100, 0x104, 0x108, 0x10C with out_ready=0.
  - Required after filling: count=4, in_ready=0, and a fifth push is refused.
  - Stimulus: then set out_ready=1.
  - Required: pops in order 0x100..0x10C, count reaches 0.
- Streaming:
  - Stimulus: continuous push and pop for 20 cycles, starting from count=1.
  - Required: count stays 1 and output order matches input order across pointer wrap.
- Halt:
  - Stimulus: count=2 with head 0x200; assert halt for 3 cycles while pushing 0x208.
  - Required during halt: out_valid=0, out_instr=STALL_INSTRUCTION, count=3.
  - Required after release: head is 0x200.
- Flush:
  - Stimulus: count=3; assert flush with in_valid=1 and out_ready=1 in the same cycle.
  - Required: next cycle count=0 and out_valid=0, and the pushed entry is absent.
- Asynchronous reset mid-operation:
  - Stimulus: drop rst between clock edges with count=2.
  - Required: out_valid falls before the next edge and count=0.
